// File: rtl/wb_csrbrg_pkg.sv
// wb_csrbrg_pkg: FSM state codes, Wishbone CTI codes and the byte-lane merge shared by wb_csrbrg
package wb_csrbrg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t WR_ACK  = 2'd1;
    localparam state_t RD_WAIT = 2'd2;
    localparam state_t RD_CAP  = 2'd3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                               input logic [3:0] sel);
        logic [31:0] out_d;
        out_d = old_d;
        for (int n = 0; n < 4; n++) out_d[8*n +: 8] = sel[n] ? new_d[8*n +: 8] : old_d[8*n +: 8];
        return out_d;
    endfunction

endpackage

// File: rtl/wb_csrbrg.sv
// wb_csrbrg: Wishbone classic to CSR bus bridge; define WB_CSRBRG_RMW_EN to merge partial-byte writes by read-modify-write
module wb_csrbrg
    import wb_csrbrg_pkg::*;
#(
    parameter int CSR_ADDR_W = 14
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [2:0]            wb_cti_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    output logic [CSR_ADDR_W-1:0] csr_a,
    output logic                  csr_we,
    output logic [31:0]           csr_do,
    input  logic [31:0]           csr_di
);

    state_t state;
    logic   req;
    logic   full_wr;
    logic   unused_ok;

    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

`ifdef WB_CSRBRG_RMW_EN
    assign full_wr   = wb_we_i & (wb_sel_i == 4'hF);
    assign unused_ok = &{1'b0, wb_cti_i, wb_adr_i[31:CSR_ADDR_W+2], wb_adr_i[1:0]};
`else
    assign full_wr   = wb_we_i;
    assign unused_ok = &{1'b0, wb_cti_i, wb_sel_i, wb_adr_i[31:CSR_ADDR_W+2], wb_adr_i[1:0]};
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            csr_a    <= '0;
            csr_we   <= 1'b0;
            csr_do   <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    csr_a <= wb_adr_i[CSR_ADDR_W+1:2];
                    if (full_wr) begin
                        csr_do   <= wb_dat_i;
                        csr_we   <= 1'b1;
                        wb_ack_o <= 1'b1;
                        state    <= WR_ACK;
                    end else begin
                        csr_we <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                WR_ACK: begin
                    csr_we   <= 1'b0;
                    wb_ack_o <= 1'b0;
                    state    <= IDLE;
                end
                RD_WAIT: state <= wb_cyc_i ? RD_CAP : IDLE;
                RD_CAP: if (!wb_cyc_i) begin
                    state <= IDLE;
                end else begin
`ifdef WB_CSRBRG_RMW_EN
                    if (wb_we_i) begin
                        csr_do <= byte_merge(csr_di, wb_dat_i, wb_sel_i);
                        csr_we <= 1'b1;
                    end else
`endif
                    wb_dat_o <= csr_di;
                    wb_ack_o <= 1'b1;
                    state    <= WR_ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
